// File: rtl/fp_result_writeback.sv
// Show-ahead result buffer between an FP multiply pipeline and its consumer, with
// issue credits, sticky flags and overrun detection. Optional FP_WB_CANON_NAN_EN canonicalises NaNs.
module fp_result_writeback #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ok,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    input  logic        res_of,
    input  logic        res_uf,
    input  logic        res_nx,
    input  logic        res_nv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_flags,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic        overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count, outstanding;
    logic            full, push, pop, take_issue, drop_credit;
    logic [31:0]     store_data;
    entry_t          head;

    assign full        = (count == DEPTH_C);
    assign out_valid   = (count != '0);
    assign pop         = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push        = res_valid & (~full | pop);
    assign issue_ok    = (outstanding < DEPTH_C);
    assign take_issue  = issue_valid & issue_ok;
    assign drop_credit = pop & (outstanding != '0);

    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head.data  : 32'h0;
    assign out_flags = out_valid ? head.flags : 5'h0;

`ifdef FP_WB_CANON_NAN_EN
    always_comb begin
        store_data = res_data;
        if (res_data[30:23] == 8'hFF && res_data[22:0] != 23'h0)
            store_data = 32'h7FC00000;
    end
`else
    assign store_data = res_data;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{flags: {res_nv, 1'b0, res_of, res_uf, res_nx}, data: store_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            fflags      <= '0;
            overrun     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (take_issue && !drop_credit)      outstanding <= outstanding + 1'b1;
            else if (drop_credit && !take_issue) outstanding <= outstanding - 1'b1;

            if (res_valid && full && !pop) overrun <= 1'b1;

            if (pop)             fflags <= (fflags_clr ? 5'h0 : fflags) | out_flags;
            else if (fflags_clr) fflags <= 5'h0;
        end
    end
endmodule

// File: tb/tb_fp_result_writeback.sv
// Directed self-checking bench for fp_result_writeback (depth 8); honours FP_WB_CANON_NAN_EN.
module tb_fp_result_writeback;
    logic        clk = 1'b0;
    logic        rst, issue_valid, issue_ok, res_valid;
    logic [31:0] res_data, out_data;
    logic        res_of, res_uf, res_nx, res_nv;
    logic        out_valid, out_ready, fflags_clr, overrun;
    logic [4:0]  out_flags, fflags;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] nan_exp;

    fp_result_writeback #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ok(issue_ok),
        .res_valid(res_valid), .res_data(res_data), .res_of(res_of), .res_uf(res_uf),
        .res_nx(res_nx), .res_nv(res_nv), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags), .fflags(fflags),
        .fflags_clr(fflags_clr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_res(input logic v, input logic [31:0] d, input logic nv, input logic of_,
                           input logic uf, input logic nx);
        res_valid = v; res_data = d; res_nv = nv; res_of = of_; res_uf = uf; res_nx = nx;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_issue_ok", 32'(issue_ok), 32'd1);
        chk("rst_fflags", 32'(fflags), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // single result, consumer ready
        issue_valid = 1'b1; tick(); issue_valid = 1'b0;
        set_res(1'b1, 32'h40C00000, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1 chk("no_comb_path", 32'(out_valid), 32'd0);
        tick();
        res_valid = 1'b0;
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data", out_data, 32'h40C00000);
        chk("basic_flags", 32'(out_flags), 32'd0);
        tick();
        chk("basic_popped", 32'(out_valid), 32'd0);
        chk("basic_fflags", 32'(fflags), 32'd0);
        chk("basic_issue_ok", 32'(issue_ok), 32'd1);

        // fill credits and buffer with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1; tick();
        end
        chk("credit_exhausted", 32'(issue_ok), 32'd0);
        tick();  // issue attempt while blocked is ignored
        issue_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_res(1'b1, 32'h3F800000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0); tick();
        end
        res_valid = 1'b0;
        chk("full_head", out_data, 32'h3F800000);
        chk("full_no_overrun", 32'(overrun), 32'd0);
        chk("full_issue_ok", 32'(issue_ok), 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pop_frees_credit", 32'(issue_ok), 32'd1);
        chk("pop_next_head", out_data, 32'h3F800001);

        // refill to full, then push+pop at full, then push at full without pop
        issue_valid = 1'b1; set_res(1'b1, 32'h3F800008, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        issue_valid = 1'b0;
        chk("refull_issue_ok", 32'(issue_ok), 32'd0);
        set_res(1'b1, 32'h3F800009, 1'b0, 1'b0, 1'b0, 1'b0); out_ready = 1'b1; tick();
        chk("full_pushpop_overrun", 32'(overrun), 32'd0);
        chk("full_pushpop_head", out_data, 32'h3F800002);
        set_res(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0); out_ready = 1'b0; tick();
        res_valid = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        for (int i = 2; i < 10; i++) begin
            chk($sformatf("drain_%0d", i), out_data, 32'h3F800000 + 32'(i));
            tick();
        end
        chk("dropped_not_stored", 32'(out_valid), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        out_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);

        // sticky flags
        out_ready = 1'b1;
        set_res(1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        res_valid = 1'b0;
        chk("flags_head", 32'(out_flags), 32'h05);
        tick();
        chk("fflags_acc", 32'(fflags), 32'h05);
        set_res(1'b1, 32'h7FC00000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        res_valid = 1'b0; fflags_clr = 1'b1; tick();
        chk("fflags_clr_pop", 32'(fflags), 32'h10);
        tick();
        fflags_clr = 1'b0;
        chk("fflags_clr_only", 32'(fflags), 32'h00);

        // NaN canonicalisation
`ifdef FP_WB_CANON_NAN_EN
        nan_exp = 32'h7FC00000;
`else
        nan_exp = 32'h7FA00001;
`endif
        out_ready = 1'b0;
        set_res(1'b1, 32'h7FA00001, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        set_res(1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        res_valid = 1'b0;
        chk("nan_store", out_data, nan_exp);
        out_ready = 1'b1; tick();
        chk("inf_unchanged", out_data, 32'h7F800000);
        tick(); out_ready = 1'b0;

        // reset mid-operation with buffered and in-flight results
        set_res(1'b1, 32'h3F000000, 1'b0, 1'b0, 1'b0, 1'b1); out_ready = 1'b1; tick();
        res_valid = 1'b0; tick(); out_ready = 1'b0;
        chk("pre_rst_fflags", 32'(fflags), 32'h01);
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1; tick();
        end
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_res(1'b1, 32'h40000000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0); tick();
        end
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0; res_valid = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_issue_ok", 32'(issue_ok), 32'd1);
        chk("mid_rst_fflags", 32'(fflags), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        tick();
        chk("rst_cycle_res_ignored", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
